// File: rtl/instr_mem_responder_if.sv
// Fetch-side bus between the fetch stage (master) and the instruction
// memory responder (slave): a request channel carrying the PC and a
// response channel returning the instruction word.
interface instr_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;

  modport master (
    output req_valid, req_addr, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/instr_mem_responder.sv
// Instruction-memory slave for the fetch stage. A request is accepted,
// held for LATENCY wait cycles, and the word (or an error with NOP_WORD)
// is captured on the edge that enters RESP and held until handshaken.
// A side load port writes program words at any time.
module instr_mem_responder #(
  parameter int          DEPTH    = 1024,
  parameter int          LATENCY  = 1,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  instr_mem_responder_if.slave  bus,
  input  logic                  load_en,
  input  logic [31:0]           load_addr,
  input  logic [31:0]           load_data,
  output logic                  busy
);

  localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] DEPTH_W = 32'(DEPTH);
  localparam logic [3:0]  LAT_W   = 4'(LATENCY);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state, state_n;
  logic [3:0]  cnt, cnt_n;
  logic [31:0] addr_q;
  logic [31:0] rsp_data_q;
  logic        rsp_err_q;
  logic        req_ready;
  logic        accept;
  logic        capture;
  logic [31:0] cap_addr;
  logic        cap_err;
  logic [31:0] cap_word;

  logic [31:0] mem [DEPTH];

  // Word index is a plain truncation of addr[31:2]; anything past the end
  // is rejected rather than aliased.
  function automatic logic in_range(input logic [31:0] a);
    return ({2'b00, a[31:2]} < DEPTH_W);
  endfunction

  function automatic logic addr_error(input logic [31:0] a);
    return (a[1:0] != 2'b00) || !in_range(a);
  endfunction

  // The byte-lane bits of the load address carry no information.
  logic unused_load_lsb;
  assign unused_load_lsb = ^load_addr[1:0];

  // Next-state, handshake and capture control.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    capture = 1'b0;
    case (state)
      IDLE:    req_ready = 1'b1;
      RESP:    req_ready = bus.rsp_ready;
      default: req_ready = 1'b0;
    endcase
    accept = bus.req_valid & req_ready;
    case (state)
      WAIT: begin
        if (cnt == 4'd1) begin
          state_n = RESP;
          capture = 1'b1;
          cnt_n   = 4'd0;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) state_n = IDLE;
      end
      default: state_n = state;
    endcase
    // A new accept (from IDLE or back-to-back out of RESP) overrides the above.
    if (accept) begin
      if (LAT_W == 4'd0) begin
        state_n = RESP;
        capture = 1'b1;
        cnt_n   = 4'd0;
      end else begin
        state_n = WAIT;
        cnt_n   = LAT_W;
      end
    end
  end

  // With zero latency the word is captured on the accept edge itself, so it
  // must come straight from the request rather than the latched address.
  assign cap_addr = (LAT_W == 4'd0) ? bus.req_addr : addr_q;
  assign cap_err  = addr_error(cap_addr);
  assign cap_word = cap_err ? NOP_WORD : mem[cap_addr[AW+1:2]];

  // Control state, latched request address and the held response word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      addr_q     <= 32'd0;
      rsp_data_q <= 32'd0;
      rsp_err_q  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (accept) addr_q <= bus.req_addr;
      if (capture) begin
        rsp_data_q <= cap_word;
        rsp_err_q  <= cap_err;
      end
    end
  end

  // Program load port; the read above sees the pre-write contents on the same edge.
  always_ff @(posedge clk) begin
    if (load_en && in_range(load_addr)) mem[load_addr[AW+1:2]] <= load_data;
  end

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;
  assign busy          = (state != IDLE);

endmodule
